// File: rtl/debug_sequencer.sv
// Debug sequencer: loads instruction memory from a UART byte stream and
// controls pipeline execution (free-run or single-step) until a halt retires.
module debug_sequencer #(
  parameter int NB_INSTR = 32,
  parameter int N_ADDR   = 2048,
  parameter int NB_ADDR  = $clog2(N_ADDR),
  parameter int NB_CNT   = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_halt,
  output logic                o_mem_wr_en,
  output logic [NB_ADDR-1:0]  o_mem_wr_addr,
  output logic [NB_INSTR-1:0] o_mem_wr_data,
  output logic                o_valid,
  output logic                o_pipe_reset,
  output logic [2:0]          o_state,
  output logic [NB_CNT-1:0]   o_cycle_count,
  output logic                o_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_LOAD   = 3'd3;
  localparam logic [2:0] ST_PRST   = 3'd4;
  localparam logic [2:0] ST_RUN    = 3'd5;
  localparam logic [2:0] ST_STEP   = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_EXIT = 8'h45;

  localparam logic [NB_ADDR-1:0] ADDR_LAST = NB_ADDR'(N_ADDR - 1);

  logic [2:0]          state_reg, state_next;
  logic [7:0]          len_lo_reg, len_lo_next;
  logic [15:0]         words_left_reg, words_left_next;
  logic [1:0]          byte_cnt_reg, byte_cnt_next;
  logic [31:0]         word_reg, word_next;
  logic [NB_ADDR-1:0]  addr_ptr_reg, addr_ptr_next;
  logic                wr_en_reg, wr_en_next;
  logic [NB_ADDR-1:0]  wr_addr_reg, wr_addr_next;
  logic [NB_INSTR-1:0] wr_data_reg, wr_data_next;
  logic                step_mode_reg, step_mode_next;
  logic                step_pulse_reg, step_pulse_next;
  logic [NB_CNT-1:0]   cycle_cnt_reg, cycle_cnt_next;

  logic        valid;
  logic [31:0] word_full;
  logic [15:0] len_full;

  assign valid     = ((state_reg == ST_RUN) && !i_halt) ||
                     ((state_reg == ST_STEP) && step_pulse_reg);
  assign word_full = {i_rx_data, word_reg[31:8]};
  assign len_full  = {i_rx_data, len_lo_reg};

  always_comb begin
    state_next      = state_reg;
    len_lo_next     = len_lo_reg;
    words_left_next = words_left_reg;
    byte_cnt_next   = byte_cnt_reg;
    word_next       = word_reg;
    addr_ptr_next   = addr_ptr_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    step_mode_next  = step_mode_reg;
    step_pulse_next = 1'b0;
    cycle_cnt_next  = cycle_cnt_reg;

    if (valid && (cycle_cnt_reg != '1))
      cycle_cnt_next = cycle_cnt_reg + NB_CNT'(1);

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            state_next    = ST_LEN_LO;
            addr_ptr_next = '0;
            byte_cnt_next = '0;
          end else if ((i_rx_data == CMD_RUN) || (i_rx_data == CMD_STEP)) begin
            state_next     = ST_PRST;
            step_mode_next = (i_rx_data == CMD_STEP);
            cycle_cnt_next = '0;
          end
        end
      end
      ST_LEN_LO: begin
        if (i_rx_valid) begin
          len_lo_next = i_rx_data;
          state_next  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (i_rx_valid) begin
          words_left_next = len_full;
          state_next      = (len_full == 16'd0) ? ST_IDLE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (i_rx_valid) begin
          word_next     = word_full;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            // Write is registered, so the pulse lands in the cycle after the 4th byte.
            wr_en_next      = 1'b1;
            wr_addr_next    = addr_ptr_reg;
            wr_data_next    = NB_INSTR'(word_full);
            addr_ptr_next   = (addr_ptr_reg == ADDR_LAST) ? '0 : addr_ptr_reg + NB_ADDR'(1);
            words_left_next = words_left_reg - 16'd1;
            if (words_left_reg == 16'd1)
              state_next = ST_IDLE;
          end
        end
      end
      ST_PRST: begin
        state_next = step_mode_reg ? ST_STEP : ST_RUN;
      end
      ST_RUN: begin
        if (i_halt)
          state_next = ST_DONE;
      end
      ST_STEP: begin
        // Halt wins over a step request arriving in the same cycle.
        if (i_halt) begin
          state_next = ST_DONE;
        end else if (i_rx_valid) begin
          if (i_rx_data == CMD_STEP)
            step_pulse_next = 1'b1;
          else if (i_rx_data == CMD_EXIT)
            state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg      <= ST_IDLE;
      len_lo_reg     <= '0;
      words_left_reg <= '0;
      byte_cnt_reg   <= '0;
      word_reg       <= '0;
      addr_ptr_reg   <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      step_mode_reg  <= 1'b0;
      step_pulse_reg <= 1'b0;
      cycle_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      len_lo_reg     <= len_lo_next;
      words_left_reg <= words_left_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_reg       <= word_next;
      addr_ptr_reg   <= addr_ptr_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      step_mode_reg  <= step_mode_next;
      step_pulse_reg <= step_pulse_next;
      cycle_cnt_reg  <= cycle_cnt_next;
    end
  end

  assign o_mem_wr_en   = wr_en_reg;
  assign o_mem_wr_addr = wr_addr_reg;
  assign o_mem_wr_data = wr_data_reg;
  assign o_valid       = valid;
  assign o_pipe_reset  = (state_reg == ST_PRST);
  assign o_state       = state_reg;
  assign o_cycle_count = cycle_cnt_reg;
  assign o_done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_debug_sequencer.sv
// Directed bench for debug_sequencer: load framing, address wrap, run/step/halt
// control and asynchronous reset behaviour, checked against hand-computed values.
module tb_debug_sequencer;

  localparam int NB_INSTR = 32;
  localparam int N_ADDR   = 2048;
  localparam int NB_ADDR  = 11;
  localparam int NB_CNT   = 32;

  localparam logic [7:0] LOAD_SEQ [11] = '{8'h4C, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33,
                                           8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  logic                i_clock    = 1'b0;
  logic                i_reset    = 1'b0;
  logic [7:0]          i_rx_data  = 8'h00;
  logic                i_rx_valid = 1'b0;
  logic                i_halt     = 1'b0;
  logic                o_mem_wr_en;
  logic [NB_ADDR-1:0]  o_mem_wr_addr;
  logic [NB_INSTR-1:0] o_mem_wr_data;
  logic                o_valid;
  logic                o_pipe_reset;
  logic [2:0]          o_state;
  logic [NB_CNT-1:0]   o_cycle_count;
  logic                o_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_cycles = 0;
  logic [NB_ADDR-1:0]  wq_addr [$];
  logic [NB_INSTR-1:0] wq_data [$];

  debug_sequencer #(
    .NB_INSTR (NB_INSTR),
    .N_ADDR   (N_ADDR),
    .NB_ADDR  (NB_ADDR),
    .NB_CNT   (NB_CNT)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_rx_data     (i_rx_data),
    .i_rx_valid    (i_rx_valid),
    .i_halt        (i_halt),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_wr_addr (o_mem_wr_addr),
    .o_mem_wr_data (o_mem_wr_data),
    .o_valid       (o_valid),
    .o_pipe_reset  (o_pipe_reset),
    .o_state       (o_state),
    .o_cycle_count (o_cycle_count),
    .o_done        (o_done)
  );

  always #5 i_clock = ~i_clock;

  // Every write-strobe cycle and every pipeline-advance cycle is logged on the falling edge.
  always @(negedge i_clock) begin
    if (o_mem_wr_en === 1'b1) begin
      wq_addr.push_back(o_mem_wr_addr);
      wq_data.push_back(o_mem_wr_data);
    end
    if (o_valid === 1'b1)
      valid_cycles++;
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step_cycle();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clock);
    #1;
    i_rx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int vbase;

    // Reset values
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    check_value("rst_state",      o_state,       0);
    check_value("rst_wr_en",      o_mem_wr_en,   0);
    check_value("rst_wr_addr",    o_mem_wr_addr, 0);
    check_value("rst_wr_data",    o_mem_wr_data, 0);
    check_value("rst_valid",      o_valid,       0);
    check_value("rst_pipe_reset", o_pipe_reset,  0);
    check_value("rst_count",      o_cycle_count, 0);
    check_value("rst_done",       o_done,        0);
    i_reset = 1'b1;
    step_cycle();
    check_value("idle_after_rst", o_state, 0);

    // Two-word load
    base = wq_addr.size();
    for (int i = 0; i < 10; i++) send_byte(LOAD_SEQ[i]);
    check_value("load_state", o_state, 3);
    send_byte(LOAD_SEQ[10]);
    check_value("load_end_state", o_state, 0);
    check_value("load_end_wr_en", o_mem_wr_en, 1);
    check_value("load_end_addr",  o_mem_wr_addr, 1);
    check_value("load_end_data",  o_mem_wr_data, 32'hDDCCBBAA);
    step_cycle();
    check_value("load_wr_en_drop", o_mem_wr_en, 0);
    repeat (2) step_cycle();
    check_value("load_nwrites", wq_addr.size() - base, 2);
    check_value("load_w0_addr", wq_addr[base],     0);
    check_value("load_w0_data", wq_data[base],     32'h44332211);
    check_value("load_w1_addr", wq_addr[base + 1], 1);
    check_value("load_w1_data", wq_data[base + 1], 32'hDDCCBBAA);

    // Zero-length load returns to IDLE
    send_byte(8'h4C);
    check_value("len0_lenlo_state", o_state, 1);
    send_byte(8'h00);
    check_value("len0_lenhi_state", o_state, 2);
    send_byte(8'h00);
    check_value("len0_idle_state", o_state, 0);

    // Unknown bytes and halt are ignored in IDLE
    send_byte(8'h45);
    send_byte(8'h00);
    check_value("ignore_byte_state", o_state, 0);
    i_halt = 1'b1;
    @(negedge i_clock);
    check_value("idle_halt_valid", o_valid, 0);
    step_cycle();
    check_value("idle_halt_state", o_state, 0);
    i_halt = 1'b0;

    // Reset in the middle of a load discards the partial word
    base = wq_addr.size();
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge i_clock);
    check_value("midload_state", o_state, 3);
    i_reset = 1'b0;
    #1;
    check_value("midload_rst_state", o_state, 0);
    check_value("midload_rst_wr_en", o_mem_wr_en, 0);
    check_value("midload_rst_addr",  o_mem_wr_addr, 0);
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    step_cycle();
    check_value("midload_release_state", o_state, 0);
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (3) step_cycle();
    check_value("midload_no_write", wq_addr.size() - base, 0);
    check_value("midload_idle",     o_state, 0);

    // Free run, halt 10 cycles after PRST
    vbase = valid_cycles;
    send_byte(8'h52);
    @(negedge i_clock);
    check_value("run_prst_state", o_state, 4);
    check_value("run_prst_pipe_reset", o_pipe_reset, 1);
    check_value("run_prst_count", o_cycle_count, 0);
    check_value("run_prst_valid", o_valid, 0);
    repeat (11) @(posedge i_clock);
    #1;
    check_value("run_before_halt_state", o_state, 5);
    i_halt = 1'b1;
    @(negedge i_clock);
    check_value("run_halt_valid", o_valid, 0);
    step_cycle();
    i_halt = 1'b0;
    check_value("run_done_state", o_state, 7);
    check_value("run_done_flag",  o_done, 1);
    check_value("run_count",      o_cycle_count, 10);
    step_cycle();
    check_value("run_valid_cycles", valid_cycles - vbase, 10);

    // Single step: enter with 'S', then three step pulses 5 cycles apart
    send_byte(8'h53);
    @(negedge i_clock);
    check_value("step_prst_state", o_state, 4);
    check_value("step_prst_count", o_cycle_count, 0);
    step_cycle();
    step_cycle();
    check_value("step_state", o_state, 6);
    check_value("step_idle_valid", o_valid, 0);
    vbase = valid_cycles;
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h53);
      @(negedge i_clock);
      check_value($sformatf("step_pulse%0d", k), o_valid, 1);
      step_cycle();
      check_value($sformatf("step_pulse%0d_end", k), o_valid, 0);
      repeat (3) step_cycle();
    end
    check_value("step_count", o_cycle_count, 3);
    check_value("step_valid_cycles", valid_cycles - vbase, 3);
    send_byte(8'h45);
    i_halt = 1'b1;
    check_value("step_exit_state", o_state, 5);
    @(negedge i_clock);
    check_value("step_exit_halt_valid", o_valid, 0);
    step_cycle();
    i_halt = 1'b0;
    check_value("step_exit_done", o_state, 7);
    check_value("step_exit_count", o_cycle_count, 3);

    // 'S' and halt together in STEP: halt wins, no pulse
    send_byte(8'h53);
    step_cycle();
    check_value("collide_step_state", o_state, 6);
    vbase = valid_cycles;
    i_rx_data  = 8'h53;
    i_rx_valid = 1'b1;
    i_halt     = 1'b1;
    step_cycle();
    i_rx_valid = 1'b0;
    i_halt     = 1'b0;
    check_value("collide_state", o_state, 7);
    repeat (2) step_cycle();
    check_value("collide_count", o_cycle_count, 0);
    check_value("collide_valid_cycles", valid_cycles - vbase, 0);

    // Load 2049 words: the last one wraps to address 0
    base = wq_addr.size();
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'h08);
    for (int w = 0; w < 2049; w++) begin
      send_byte(8'(w));
      send_byte(8'(w >> 8));
      send_byte(8'h00);
      send_byte(8'h00);
    end
    check_value("wrap_end_state", o_state, 0);
    repeat (2) step_cycle();
    check_value("wrap_nwrites", wq_addr.size() - base, 2049);
    check_value("wrap_w2047_addr", wq_addr[base + 2047], 2047);
    check_value("wrap_w2047_data", wq_data[base + 2047], 2047);
    check_value("wrap_w2048_addr", wq_addr[base + 2048], 0);
    check_value("wrap_w2048_data", wq_data[base + 2048], 2048);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
